// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC-addressed memory read into IR, decoded next-PC operands
//
// Purpose: on a one-cycle FetchStart from control, issues a read of the
// instruction word at PC. It holds MemAddr/MemRead stable until MemReady
// arrives or TIMEOUT wait cycles elapse. It then loads IR and pulses
// InstrValid, or raises the sticky FetchErr. The decoded fields feed the PC
// source selection logic.
//
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   PC           current program counter (sampled only when a fetch is accepted)
//   FetchStart   one-cycle fetch request (ignored while Busy)
//   MemData      instruction memory read data
//   MemReady     read data valid this cycle (ignored while idle)
//   MemAddr      registered fetch address
//   MemRead      registered read strobe
//   IR           instruction register
//   Opcode       IR[15:12]
//   Imm8         IR[7:0], raw
//   JumpTarget   {page of the PC that fetched IR, IR[11:0]}
//   isBranch     Opcode == BRANCH_OP
//   isJump       Opcode == JUMP_OP
//   InstrValid   one-cycle pulse after IR loads
//   Busy         fetch outstanding
//   FetchErr     sticky timeout flag, cleared by the next accepted fetch

module instr_fetch #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [3:0]  BRANCH_OP = 4'hB,
  parameter logic [3:0]  JUMP_OP   = 4'hC
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] PC,
  input  logic        FetchStart,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [15:0] IR,
  output logic [3:0]  Opcode,
  output logic [7:0]  Imm8,
  output logic [15:0] JumpTarget,
  output logic        isBranch,
  output logic        isJump,
  output logic        InstrValid,
  output logic        Busy,
  output logic        FetchErr
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  count, count_nx;
  // Only the page bits of the fetch PC are observable (via JumpTarget).
  logic [3:0]  fetch_page, fetch_page_nx;
  // Page captured alongside IR. JumpTarget therefore changes only on the
  // edge IR loads, not when a later fetch starts or times out.
  logic [3:0]  ir_page, ir_page_nx;
  logic [15:0] mem_addr_nx, ir_nx;
  logic        mem_read_nx, instr_valid_nx, fetch_err_nx;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      count      <= 8'd0;
      fetch_page <= 4'd0;
      ir_page    <= 4'd0;
      MemAddr    <= 16'd0;
      MemRead    <= 1'b0;
      IR         <= 16'd0;
      InstrValid <= 1'b0;
      FetchErr   <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      fetch_page <= fetch_page_nx;
      ir_page    <= ir_page_nx;
      MemAddr    <= mem_addr_nx;
      MemRead    <= mem_read_nx;
      IR         <= ir_nx;
      InstrValid <= instr_valid_nx;
      FetchErr   <= fetch_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    count_nx       = count;
    fetch_page_nx  = fetch_page;
    ir_page_nx     = ir_page;
    mem_addr_nx    = MemAddr;
    mem_read_nx    = MemRead;
    ir_nx          = IR;
    instr_valid_nx = 1'b0;
    fetch_err_nx   = FetchErr;
    case (state)
      IDLE: begin
        mem_read_nx = 1'b0;
        if (FetchStart) begin
          mem_addr_nx   = PC;
          fetch_page_nx = PC[15:12];
          mem_read_nx   = 1'b1;
          count_nx      = 8'd0;
          fetch_err_nx  = 1'b0;
          state_nx      = WAIT;
        end
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (MemReady) begin
          ir_nx          = MemData;
          ir_page_nx     = fetch_page;
          mem_read_nx    = 1'b0;
          instr_valid_nx = 1'b1;
          state_nx       = IDLE;
        end else if (count == LAST_COUNT) begin
          mem_read_nx  = 1'b0;
          fetch_err_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          count_nx = count + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Busy       = (state == WAIT);
  assign Opcode     = IR[15:12];
  assign Imm8       = IR[7:0];
  assign JumpTarget = {ir_page, IR[11:0]};
  assign isBranch   = (IR[15:12] == BRANCH_OP);
  assign isJump     = (IR[15:12] == JUMP_OP);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch

module tb_instr_fetch;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] PC = 16'd0;
  logic        FetchStart = 1'b0;
  logic [15:0] MemData = 16'd0;
  logic        MemReady = 1'b0;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [15:0] IR;
  logic [3:0]  Opcode;
  logic [7:0]  Imm8;
  logic [15:0] JumpTarget;
  logic        isBranch;
  logic        isJump;
  logic        InstrValid;
  logic        Busy;
  logic        FetchErr;

  instr_fetch #(.TIMEOUT(TIMEOUT), .BRANCH_OP(4'hB), .JUMP_OP(4'hC)) dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .FetchStart(FetchStart),
    .MemData(MemData), .MemReady(MemReady), .MemAddr(MemAddr),
    .MemRead(MemRead), .IR(IR), .Opcode(Opcode), .Imm8(Imm8),
    .JumpTarget(JumpTarget), .isBranch(isBranch), .isJump(isJump),
    .InstrValid(InstrValid), .Busy(Busy), .FetchErr(FetchErr)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
    int          delay;   // MemReady sampled at edge k+delay; > TIMEOUT means never
    logic [15:0] e_ir;
    logic [15:0] e_jt;
    logic        e_br;
    logic        e_jmp;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  // Transaction-level reference state for the random phase
  logic [15:0] m_ir;
  logic [15:0] m_jt;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch starting this cycle; ends right after the completing edge so a
  // following call issues its FetchStart in the InstrValid cycle.
  task automatic run_fetch(input logic [15:0] pc, input logic [15:0] data, input int delay,
                           input logic [15:0] e_ir, input logic [15:0] e_jt,
                           input logic e_br, input logic e_jmp, input logic e_err);
    int fin;
    fin = (delay <= TIMEOUT) ? delay : TIMEOUT;
    PC = pc;
    FetchStart = 1'b1;
    MemReady = 1'b0;
    tick();
    for (int c = 0; c <= fin; c++) begin
      if (c < fin) begin
        chk("memread_wait", 32'(MemRead), 32'd1);
        chk("memaddr_wait", 32'(MemAddr), 32'(pc));
        chk("busy_wait", 32'(Busy), 32'd1);
        chk("ivalid_wait", 32'(InstrValid), 32'd0);
        chk("err_wait", 32'(FetchErr), 32'd0);
        PC = 16'($urandom);
        FetchStart = 1'($urandom_range(0, 1));
        MemReady = (c + 1 == delay);
        MemData = MemReady ? data : 16'($urandom);
        tick();
      end else begin
        chk("memread_end", 32'(MemRead), 32'd0);
        chk("busy_end", 32'(Busy), 32'd0);
        chk("ivalid_end", 32'(InstrValid), 32'(!e_err));
        chk("err_end", 32'(FetchErr), 32'(e_err));
        chk("ir", 32'(IR), 32'(e_ir));
        chk("opcode", 32'(Opcode), 32'(e_ir[15:12]));
        chk("imm8", 32'(Imm8), 32'(e_ir[7:0]));
        chk("jumptarget", 32'(JumpTarget), 32'(e_jt));
        chk("isbranch", 32'(isBranch), 32'(e_br));
        chk("isjump", 32'(isJump), 32'(e_jmp));
      end
    end
    FetchStart = 1'b0;
    MemReady = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'hB07F, 1,  16'hB07F, 16'h107F, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'hA010, 16'hC456, 6,  16'hC456, 16'hA456, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0002, 16'h1ABC, 2,  16'h1ABC, 16'h0ABC, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h3000, 16'h2222, 99, 16'h1ABC, 16'h0ABC, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h4321, 16'hC0DE, 15, 16'hC0DE, 16'h40DE, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 16, 16'hC0DE, 16'h40DE, 1'b0, 1'b1, 1'b1};

    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_ir", 32'(IR), 32'd0);
    chk("rst_jt", 32'(JumpTarget), 32'd0);
    chk("rst_flags", 32'({isBranch, isJump, InstrValid, Busy, FetchErr}), 32'd0);
    chk("rst_fields", 32'({Opcode, Imm8}), 32'd0);

    // Directed table, applied back to back
    foreach (vecs[i])
      run_fetch(vecs[i].pc, vecs[i].data, vecs[i].delay, vecs[i].e_ir,
                vecs[i].e_jt, vecs[i].e_br, vecs[i].e_jmp, vecs[i].e_err);
    tick();
    chk("ivalid_single_pulse", 32'(InstrValid), 32'd0);

    // Stray MemReady while idle
    MemReady = 1'b1;
    MemData = 16'hFFFF;
    tick();
    MemReady = 1'b0;
    tick();
    chk("stray_ir", 32'(IR), 32'h0000C0DE);
    chk("stray_ivalid", 32'(InstrValid), 32'd0);
    chk("stray_busy", 32'(Busy), 32'd0);
    chk("stray_err_sticky", 32'(FetchErr), 32'd1);

    // Reset mid-fetch with MemReady in the same cycle
    PC = 16'h5555;
    FetchStart = 1'b1;
    tick();
    FetchStart = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    MemReady = 1'b1;
    MemData = 16'hBEEF;
    tick();
    chk("midrst_ir", 32'(IR), 32'd0);
    chk("midrst_memread", 32'(MemRead), 32'd0);
    chk("midrst_memaddr", 32'(MemAddr), 32'd0);
    chk("midrst_ivalid", 32'(InstrValid), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_err", 32'(FetchErr), 32'd0);
    chk("midrst_jt", 32'(JumpTarget), 32'd0);
    Reset = 1'b0;
    MemReady = 1'b0;
    tick();
    chk("postrst_ivalid", 32'(InstrValid), 32'd0);
    chk("postrst_ir", 32'(IR), 32'd0);

    // Random fetches against the transaction-level model
    m_ir = 16'd0;
    m_jt = 16'd0;
    m_err = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [15:0] pc, data;
      int delay, gap;
      pc = 16'($urandom);
      data = 16'($urandom);
      case ($urandom_range(0, 2))
        0: data[15:12] = 4'hB;
        1: data[15:12] = 4'hC;
        default: ;
      endcase
      delay = $urandom_range(1, TIMEOUT + 3);
      if (delay <= TIMEOUT) begin
        m_ir = data;
        m_jt = {pc[15:12], data[11:0]};
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      run_fetch(pc, data, delay, m_ir, m_jt, m_ir[15:12] == 4'hB,
                m_ir[15:12] == 4'hC, m_err);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        MemReady = 1'($urandom_range(0, 1));
        MemData = 16'($urandom);
        tick();
        MemReady = 1'b0;
        chk("gap_ivalid", 32'(InstrValid), 32'd0);
        chk("gap_ir", 32'(IR), 32'(m_ir));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit multicycle datapath: on request from control it reads the instruction word at the current PC from instruction memory over a ready/strobe handshake, holds it in the instruction register, and presents the decoded fields (8-bit immediate, 16-bit jump target, branch flag) that feed the PC source selection logic (SE/ZE/shift-8 immediate paths, jump-target input, isBranch). It is the producer side of the PC update path: PC in, next-PC operands out.

## Interface
- TIMEOUT, 15: WAIT cycles without MemReady before the fetch is aborted (1..255).
- BRANCH_OP, 4'hB: opcode value that asserts isBranch.
- JUMP_OP, 4'hC: opcode value that asserts isJump.
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  16  current program counter.
- FetchStart  in  1  one-cycle fetch request from control.
- MemData  in  16  instruction memory read data.
- MemReady  in  1  memory read data valid this cycle.
- MemAddr  out  16  registered fetch address.
- MemRead  out  1  registered read strobe.
- IR  out  16  instruction register.
- Opcode  out  4  IR[15:12].
- Imm8  out  8  IR[7:0] (raw; extension done downstream).
- JumpTarget  out  16  {FetchPC[15:12], IR[11:0]}, FetchPC = PC latched at fetch start.
- isBranch  out  1  Opcode == BRANCH_OP.
- isJump  out  1  Opcode == JUMP_OP.
- InstrValid  out  1  one-cycle pulse: IR updated.
- Busy  out  1  high in WAIT.
- FetchErr  out  1  sticky timeout flag.

## Operation
- States: IDLE, WAIT. Reset → IDLE.
- Reset values: MemAddr=0, MemRead=0, IR=16'h0000, FetchPC=0, InstrValid=0, FetchErr=0, Busy=0, timeout count=0; decoded outputs follow IR (Opcode=0, Imm8=0, JumpTarget=0, isBranch=0, isJump=0).
- IDLE, FetchStart=1: MemAddr<=PC, FetchPC<=PC, MemRead<=1, count<=0, FetchErr<=0, → WAIT.
- IDLE, FetchStart=0: hold; MemRead=0.
- WAIT, MemReady=1: IR<=MemData, MemRead<=0, InstrValid<=1 (next cycle only), → IDLE.
- WAIT, MemReady=0, count==TIMEOUT-1: MemRead<=0, FetchErr<=1, IR unchanged, no InstrValid, → IDLE.
- WAIT, otherwise: count<=count+1, MemAddr/MemRead held stable.
- FetchStart while in WAIT: ignored (no queueing, no address change).
- MemReady while in IDLE: ignored.
- FetchStart in the cycle InstrValid is high: accepted (state is IDLE) → back-to-back fetch.
- PC changes during WAIT do not affect MemAddr or JumpTarget.
- Reset mid-fetch: abort immediately, all registers to reset values, outstanding MemReady ignored.
- Decoded outputs are combinational from IR/FetchPC; they change only on the edge IR loads.

## Timing
- FetchStart sampled at edge k → MemRead=1, MemAddr valid after edge k.
- MemReady sampled high at edge k+n (n≥1) → IR valid and InstrValid=1 after edge k+n; MemRead=0 same edge.
- Minimum latency FetchStart→InstrValid: 2 cycles. Busy = (state==WAIT).
- Timeout: MemRead high for exactly TIMEOUT cycles, FetchErr rises after edge k+TIMEOUT.
- FetchErr stays high until next accepted FetchStart or Reset.

## Test plan
- Reset, then PC=16'h1234, FetchStart pulse, MemReady=1 one cycle later with MemData=16'hB07F → MemAddr=16'h1234, IR=16'hB07F, Imm8=8'h7F, isBranch=1, isJump=0, InstrValid single pulse, 2-cycle latency.
- PC=16'hA010, MemData=16'hC456 delivered after 5 wait cycles, PC changed to 16'h0000 during WAIT → MemAddr stays 16'hA010, JumpTarget=16'hA456, isJump=1, Busy high 6 cycles.
- MemReady never asserted → MemRead high exactly 15 cycles, FetchErr=1, IR keeps previous value, no InstrValid; next FetchStart clears FetchErr.
- FetchStart asserted in the InstrValid cycle with PC=16'h0002 → second fetch issues MemAddr=16'h0002 with no idle gap; extra FetchStart during WAIT ignored.
- Reset asserted in WAIT with MemReady=1 same cycle → IR=0, MemRead=0, InstrValid=0, state IDLE.
- Stray MemReady in IDLE with MemData=16'hFFFF → IR unchanged, no InstrValid.
